// File: rtl/rm_feeder_pkg.sv
// Shared types for the runtime-verification symbol feeder: symbol layout,
// feeder FSM states and the commit-to-symbol packing helper.
package rm_feeder_pkg;

  localparam int SYM_W    = 8;
  localparam int CLS_LSB  = 0;
  localparam int ATTR_LSB = 4;
  localparam int CTX_LSB  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] ctx;
    logic [1:0] attr;
    logic [3:0] cls;
  } symbol_t;

  function automatic symbol_t pack_symbol(input logic [3:0] cls,
                                          input logic [1:0] attr,
                                          input logic [1:0] ctx);
    logic [SYM_W-1:0] raw;
    raw = '0;
    raw[CLS_LSB +: 4]  = cls;
    raw[ATTR_LSB +: 2] = attr;
    raw[CTX_LSB +: 2]  = ctx;
    return symbol_t'(raw);
  endfunction

endpackage

// File: rtl/rm_sym_fifo.sv
// Generic synchronous FIFO, power-of-two depth, no write-to-read bypass.
// The head entry is presented combinationally from storage.
module rm_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rm_symbol_feeder.sv
// Feeds commit events as 8-bit symbols into one automaton instance and
// reduces its report outputs to per-window violation status.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no window; automaton held in reset, commits refused
//   SYNC   | window opening; reset held SYNC_CYCLES cycles, commits buffered
//   STREAM | reset released; one buffered symbol consumed per cycle
//   DRAIN  | window closing; commits refused, remaining symbols consumed
module rm_symbol_feeder
  import rm_feeder_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int NUM_REPORTS = 4,
  parameter int SYNC_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   win_start,
  input  logic                   win_stop,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  input  logic [3:0]             commit_cls,
  input  logic [1:0]             commit_attr,
  input  logic [1:0]             commit_ctx,
  output logic                   mon_reset,
  output logic                   mon_run,
  output logic [7:0]             mon_symbols,
  input  logic [NUM_REPORTS-1:0] report_in,
  output logic                   busy,
  output logic                   violation,
  output logic [NUM_REPORTS-1:0] report_vec,
  output logic [CNT_W-1:0]       first_idx,
  output logic [CNT_W-1:0]       sym_count
);

  localparam int SC_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [SC_W-1:0] SYNC_LOAD = SC_W'(SYNC_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SC_W-1:0]  sync_cnt;
  logic             stop_pend;
  logic             win_open;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  symbol_t          wr_sym;
  symbol_t          head_sym;
  symbol_t          sym_hold;
  logic             run_d;
  logic [CNT_W-1:0] idx_d;

  assign win_open = (state == IDLE) && win_start;
  assign push     = commit_valid && commit_ready;
  assign wr_sym   = pack_symbol(commit_cls, commit_attr, commit_ctx);
  assign busy     = (state != IDLE);

  rm_sym_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(symbol_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_sym),
    .pop   (mon_run),
    .rdata (head_sym),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync_cnt  <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;

      if (win_open) begin
        sync_cnt <= SYNC_LOAD;
      end else if ((state == SYNC) && (sync_cnt != '0)) begin
        sync_cnt <= sync_cnt - SC_W'(1);
      end

      // A stop seen during SYNC waits here until streaming has started.
      if (state == IDLE) begin
        stop_pend <= 1'b0;
      end else if (win_stop && ((state == SYNC) || (state == STREAM))) begin
        stop_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    mon_reset    = 1'b0;
    mon_run      = 1'b0;
    commit_ready = 1'b0;
    case (state)
      IDLE: begin
        mon_reset = 1'b1;
        if (win_start) state_nxt = SYNC;
      end
      SYNC: begin
        mon_reset    = 1'b1;
        commit_ready = !fifo_full;
        if (sync_cnt == '0) state_nxt = STREAM;
      end
      STREAM: begin
        mon_run      = !fifo_empty;
        commit_ready = !fifo_full;
        if (win_stop || stop_pend) state_nxt = DRAIN;
      end
      DRAIN: begin
        mon_run = !fifo_empty;
        // Wait out the report of the last symbol before closing.
        if (fifo_empty && !run_d) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mon_symbols = mon_run ? head_sym : sym_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_d      <= 1'b0;
      idx_d      <= '0;
      sym_hold   <= '0;
      violation  <= 1'b0;
      report_vec <= '0;
      first_idx  <= '0;
      sym_count  <= '0;
    end else begin
      run_d <= mon_run;
      if (mon_run) begin
        idx_d    <= sym_count;
        sym_hold <= head_sym;
      end

      if (win_open) begin
        violation  <= 1'b0;
        report_vec <= '0;
        first_idx  <= '0;
        sym_count  <= '0;
      end else begin
        if (mon_run && (sym_count != '1)) sym_count <= sym_count + CNT_W'(1);

        // Reports belong to the symbol consumed one cycle earlier.
        if (run_d && (|report_in)) begin
          report_vec <= report_vec | report_in;
          if (!violation) begin
            violation <= 1'b1;
            first_idx <= idx_d;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rm_symbol_feeder.sv
// Self-checking bench for rm_symbol_feeder: packing table, scoreboarded
// symbol stream, report reduction, drain, back-pressure and reset corners.
module tb_rm_symbol_feeder;

  localparam int NR = 4;
  localparam int CW = 16;

  typedef struct {
    logic [3:0] cls;
    logic [1:0] attr;
    logic [1:0] ctx;
    logic [7:0] exp_sym;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          win_start = 1'b0;
  logic          win_stop = 1'b0;
  logic          commit_valid = 1'b0;
  logic [3:0]    commit_cls = '0;
  logic [1:0]    commit_attr = '0;
  logic [1:0]    commit_ctx = '0;
  logic [NR-1:0] rep_drv = '0;
  logic [NR-1:0] rep_force = '0;
  logic [NR-1:0] report_in;

  logic          commit_ready, mon_reset, mon_run, busy, violation;
  logic [7:0]    mon_symbols;
  logic [NR-1:0] report_vec;
  logic [CW-1:0] first_idx, sym_count;

  logic          commit_ready8, mon_reset8, mon_run8, busy8, violation8;
  logic [7:0]    mon_symbols8;
  logic [NR-1:0] report_vec8;
  logic [CW-1:0] first_idx8, sym_count8;

  int            errors = 0;
  int            checks = 0;
  int            exp_idx = 0;
  logic [7:0]    exp_q[$];
  logic [NR-1:0] rep_pat [32];
  logic [NR-1:0] next_rep = '0;
  vec_t          tbl [6];

  assign report_in = rep_drv | rep_force;

  always #5 clk = ~clk;

  rm_symbol_feeder #(.DEPTH(4), .NUM_REPORTS(NR), .SYNC_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .win_start(win_start), .win_stop(win_stop),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_cls(commit_cls), .commit_attr(commit_attr), .commit_ctx(commit_ctx),
    .mon_reset(mon_reset), .mon_run(mon_run), .mon_symbols(mon_symbols),
    .report_in(report_in), .busy(busy), .violation(violation),
    .report_vec(report_vec), .first_idx(first_idx), .sym_count(sym_count)
  );

  rm_symbol_feeder #(.DEPTH(4), .NUM_REPORTS(NR), .SYNC_CYCLES(8), .CNT_W(CW)) dut8 (
    .clk(clk), .reset(reset), .win_start(win_start), .win_stop(win_stop),
    .commit_valid(commit_valid), .commit_ready(commit_ready8),
    .commit_cls(commit_cls), .commit_attr(commit_attr), .commit_ctx(commit_ctx),
    .mon_reset(mon_reset8), .mon_run(mon_run8), .mon_symbols(mon_symbols8),
    .report_in(report_in), .busy(busy8), .violation(violation8),
    .report_vec(report_vec8), .first_idx(first_idx8), .sym_count(sym_count8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic drive_push(input logic [3:0] c, input logic [1:0] a,
                            input logic [1:0] x, input logic [7:0] sym);
    commit_valid = 1'b1;
    commit_cls   = c;
    commit_attr  = a;
    commit_ctx   = x;
    if (commit_ready) exp_q.push_back(sym);
  endtask

  task automatic rnd_push(output logic [7:0] sym);
    logic [3:0] c;
    logic [1:0] a, x;
    c = 4'($urandom_range(0, 15));
    a = 2'($urandom_range(0, 3));
    x = 2'($urandom_range(0, 3));
    sym = {x, a, c};
    drive_push(c, a, x, sym);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || busy8) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy | busy8), 32'd0);
  endtask

  // Scoreboard: every consumed symbol must match the oldest accepted commit.
  // Reports for symbol index i are driven in the cycle after its run.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      rep_drv  = '0;
      next_rep = '0;
    end else begin
      rep_drv  = next_rep;
      next_rep = '0;
      if (mon_run) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: got symbol %0h with empty scoreboard, required no run", mon_symbols);
        end else begin
          e = exp_q.pop_front();
          check("mon_symbols", 32'(mon_symbols), 32'(e));
        end
        if (exp_idx < 32) next_rep = rep_pat[exp_idx];
        exp_idx++;
      end
    end
  end

  initial begin
    logic [7:0] s;
    logic [7:0] w3_first;
    int cnt8;
    bit seen8;

    tbl[0] = '{4'h3, 2'b01, 2'b10, 8'h93};
    tbl[1] = '{4'h0, 2'b00, 2'b00, 8'h00};
    tbl[2] = '{4'hF, 2'b11, 2'b11, 8'hFF};
    tbl[3] = '{4'hA, 2'b10, 2'b01, 8'h6A};
    tbl[4] = '{4'h5, 2'b00, 2'b11, 8'hC5};
    tbl[5] = '{4'h1, 2'b11, 2'b00, 8'h31};
    for (int i = 0; i < 32; i++) rep_pat[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mon_reset", 32'(mon_reset), 32'd1);
    check("rst_mon_run", 32'(mon_run), 32'd0);
    check("rst_ready", 32'(commit_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_symbols", 32'(mon_symbols), 32'd0);
    check("rst_status", {violation, 3'b0, report_vec, first_idx[7:0], sym_count[7:0]}, 32'd0);
    reset = 1'b0;

    // Window 1: sync framing, packing table, back-to-back, full on stretched SYNC
    @(negedge clk);
    win_start = 1'b1;
    exp_idx = 0;
    @(negedge clk);
    win_start = 1'b0;
    check("w1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("w1_ready", 32'(commit_ready), 32'd1);
      check("w1_ready_dut8", 32'(commit_ready8), (i < 4) ? 32'd1 : 32'd0);
      if (i < 2) check("w1_mon_reset_sync", 32'(mon_reset), 32'd1);
      if (i == 2) check("w1_mon_reset_stream", 32'(mon_reset), 32'd0);
      if (i == 3) check("w1_sym_count_1", 32'(sym_count), 32'd1);
      drive_push(tbl[i].cls, tbl[i].attr, tbl[i].ctx, tbl[i].exp_sym);
      @(negedge clk);
    end
    commit_valid = 1'b0;
    win_stop = 1'b1;
    @(negedge clk);
    win_stop = 1'b0;
    wait_idle("w1_idle");
    check("w1_sym_count", 32'(sym_count), 32'd6);
    check("w1_violation", 32'(violation), 32'd0);
    check("w1_drained", 32'(exp_q.size()), 32'd0);

    // Window 2: reports after indices 2 and 4; report during SYNC ignored
    rep_pat[2] = 4'b0100;
    rep_pat[4] = 4'b0001;
    @(negedge clk);
    win_start = 1'b1;
    exp_idx = 0;
    @(negedge clk);
    win_start = 1'b0;
    rep_force = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) rep_force = '0;
      rnd_push(s);
      @(negedge clk);
    end
    commit_valid = 1'b0;
    win_stop = 1'b1;
    @(negedge clk);
    win_stop = 1'b0;
    wait_idle("w2_idle");
    check("w2_violation", 32'(violation), 32'd1);
    check("w2_first_idx", 32'(first_idx), 32'd2);
    check("w2_report_vec", 32'(report_vec), 32'h5);
    check("w2_sym_count", 32'(sym_count), 32'd5);
    check("w2_idle_mon_reset", 32'(mon_reset), 32'd1);
    rep_pat[2] = '0;
    rep_pat[4] = '0;
    repeat (3) @(negedge clk);
    check("w2_retained_vec", 32'(report_vec), 32'h5);
    check("w2_retained_viol", 32'(violation), 32'd1);

    // Window 3: stop during stretched SYNC with 3 buffered, then drain
    win_start = 1'b1;
    exp_idx = 0;
    @(negedge clk);
    win_start = 1'b0;
    check("w3_clear", {violation, 3'b0, report_vec, first_idx[7:0], sym_count[7:0]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      rnd_push(s);
      if (i == 0) w3_first = s;
      @(negedge clk);
    end
    commit_valid = 1'b0;
    win_stop = 1'b1;
    @(negedge clk);
    win_stop = 1'b0;
    cnt8 = 0;
    seen8 = 1'b0;
    for (int n = 0; n < 60 && busy8; n++) begin
      if (mon_run8) begin
        if (!seen8) check("w3_dut8_first_sym", 32'(mon_symbols8), 32'(w3_first));
        seen8 = 1'b1;
        cnt8++;
      end
      @(negedge clk);
    end
    check("w3_dut8_runs", 32'(cnt8), 32'd3);
    check("w3_dut8_busy", 32'(busy8), 32'd0);
    check("w3_dut8_mon_reset", 32'(mon_reset8), 32'd1);
    check("w3_dut8_sym_count", 32'(sym_count8), 32'd3);
    check("w3_dut8_status", {violation8, 3'b0, report_vec8, first_idx8[7:0]}, 32'd0);
    wait_idle("w3_idle");
    check("w3_drained", 32'(exp_q.size()), 32'd0);

    // Window 4: reset during STREAM with 2 buffered
    rep_pat[0] = 4'b0010;
    @(negedge clk);
    win_start = 1'b1;
    exp_idx = 0;
    @(negedge clk);
    win_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_push(s);
      @(negedge clk);
    end
    commit_valid = 1'b0;
    check("w4_pre_violation", 32'(violation), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("w4_mon_reset", 32'(mon_reset), 32'd1);
    check("w4_mon_run", 32'(mon_run), 32'd0);
    check("w4_violation", 32'(violation), 32'd0);
    check("w4_busy_ready", {busy, commit_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rep_pat[0] = '0;
    exp_idx = 0;
    @(negedge clk);
    win_start = 1'b1;
    @(negedge clk);
    win_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("w4_fifo_empty", 32'(mon_run), 32'd0);
    end
    win_stop = 1'b1;
    @(negedge clk);
    win_stop = 1'b0;
    wait_idle("w4_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
